// File: rtl/img_pkg.sv
// Shared image geometry and sequencing types for the pixel source and the
// smoothing filter's boundary logic.
package img_pkg;

  localparam int IMG_W     = 256;
  localparam int IMG_H     = 256;
  localparam int MIN_GAP   = 8;
  localparam int FLUSH_PIX = IMG_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Row-major raster walker: x/y position plus a linear address that wraps to
// zero after the last pixel of a frame.
module raster_addr_gen #(
  parameter int IMG_W = img_pkg::IMG_W,
  parameter int IMG_H = img_pkg::IMG_H,
  parameter int AW    = 16,
  parameter int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          last_pix
);
  import img_pkg::*;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  assign last_pix = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear || (advance && last_pix)) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      // addr tracks y*IMG_W + x without a multiplier
      addr <= addr + 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster pixel source: reads frames from a synchronous SRAM and strobes one
// pixel per period into the smoothing filter, then drains it with zero pixels.
module pixel_stream_tx #(
  parameter int IMG_W     = img_pkg::IMG_W,
  parameter int IMG_H     = img_pkg::IMG_H,
  parameter int DW        = 8,
  parameter int AW        = 16,
  parameter int MIN_GAP   = img_pkg::MIN_GAP,
  parameter int FLUSH_PIX = IMG_W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    n_frames,
  input  logic [7:0]    gap,
  input  logic          pause,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          o_strb,
  output logic [DW-1:0] o_data,
  output logic          o_sof,
  output logic          o_eof
);
  import img_pkg::*;

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(FLUSH_PIX + 1);
  localparam logic [7:0]    GAP_MIN    = 8'(MIN_GAP);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_PIX);

  state_t        state, state_nxt;
  logic [7:0]    period, pcnt, pcnt_nxt, pcnt_wrap;
  logic [7:0]    frames, frame_cnt;
  logic [FW-1:0] fcnt;
  logic          rd_nxt, sof_p, eof_p, last_p;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last_pix, clear;

  assign clear = (state == IDLE) && start;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  raster_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .XW(XW), .YW(YW)
  ) u_addr (
    .clk(clk), .rst_n(rst_n), .clear(clear), .advance(mem_rd),
    .x(x), .y(y), .addr(mem_addr), .last_pix(last_pix)
  );

  always_comb begin
    state_nxt = state;
    pcnt_wrap = (pcnt == period - 8'd1) ? 8'd0 : pcnt + 8'd1;
    pcnt_nxt  = pcnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        pcnt_nxt  = 8'd0;
      end
      RUN: begin
        // phase 0 only moves on once a read has actually been issued
        if (pcnt == 8'd0) pcnt_nxt = mem_rd ? 8'd1 : 8'd0;
        else              pcnt_nxt = pcnt_wrap;
        if (o_strb && last_p) state_nxt = FLUSH;
      end
      FLUSH: begin
        pcnt_nxt = pcnt_wrap;
        if (o_strb && (fcnt == FLUSH_LAST)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        pcnt_nxt  = 8'd0;
      end
      default: state_nxt = IDLE;
    endcase
    // the read enable is a flop, so pause is looked at one edge ahead
    rd_nxt = (state_nxt == RUN) && (pcnt_nxt == 8'd0) && !pause;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcnt      <= '0;
      period    <= '0;
      frames    <= '0;
      frame_cnt <= '0;
      fcnt      <= '0;
      mem_rd    <= 1'b0;
      sof_p     <= 1'b0;
      eof_p     <= 1'b0;
      last_p    <= 1'b0;
      o_strb    <= 1'b0;
      o_data    <= '0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
    end else begin
      state  <= state_nxt;
      pcnt   <= pcnt_nxt;
      mem_rd <= rd_nxt;
      if (clear) begin
        period    <= (gap < GAP_MIN) ? GAP_MIN : gap;
        frames    <= (n_frames == 8'd0) ? 8'd1 : n_frames;
        frame_cnt <= '0;
        fcnt      <= '0;
        last_p    <= 1'b0;
      end
      if (mem_rd) begin
        sof_p  <= (x == '0) && (y == '0);
        eof_p  <= last_pix;
        last_p <= last_pix && (frame_cnt == frames - 8'd1);
        if (last_pix) frame_cnt <= frame_cnt + 8'd1;
      end
      o_strb <= ((state == RUN) || (state == FLUSH)) && (pcnt == 8'd1);
      o_sof  <= 1'b0;
      o_eof  <= 1'b0;
      if ((state == RUN) && (pcnt == 8'd1)) begin
        o_data <= mem_rdata;
        o_sof  <= sof_p;
        o_eof  <= eof_p;
      end else if ((state == FLUSH) && (pcnt == 8'd1)) begin
        o_data <= '0;
        fcnt   <= fcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx on a small 4x3 image with a synchronous
// SRAM model and a strobe/read/done monitor.
module tb_pixel_stream_tx;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int NPIX  = W * H;
  localparam int FLUSH = W + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] n_frames = 8'd0;
  logic [7:0] gap = 8'd0;
  logic       busy, done, mem_rd, o_strb, o_sof, o_eof;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata = 8'd0;
  logic [7:0] o_data;
  logic [7:0] mem [NPIX];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  int s_cyc[$];
  int s_dat[$];
  int s_sof[$];
  int s_eof[$];
  int rd_addr[$];
  int rd_cyc[$];
  int done_cyc[$];

  pixel_stream_tx #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_frames(n_frames), .gap(gap),
    .pause(pause), .busy(busy), .done(done), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .o_strb(o_strb),
    .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  always @(negedge clk) begin
    if (o_strb) begin
      s_cyc.push_back(cyc);
      s_dat.push_back(int'(o_data));
      s_sof.push_back(int'(o_sof));
      s_eof.push_back(int'(o_eof));
    end
    if (mem_rd) begin
      rd_addr.push_back(int'(mem_addr));
      rd_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    s_cyc.delete(); s_dat.delete(); s_sof.delete(); s_eof.delete();
    rd_addr.delete(); rd_cyc.delete(); done_cyc.delete();
  endtask

  task automatic start_job(input int nf, input int g, output int e);
    @(posedge clk); #1 clear_mon();
    @(negedge clk);
    n_frames = 8'(nf);
    gap      = 8'(g);
    start    = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e = cyc;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("busy_in_done", busy, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_width", done, 0);
    end
  endtask

  task automatic check_job(input string name, input int nf, input int per, input int e, input bit timing);
    int nd, total, ed, es, ee;
    nd    = nf * NPIX;
    total = nd + FLUSH;
    check({name, "_strobes"}, s_cyc.size(), total);
    check({name, "_reads"}, rd_addr.size(), nd);
    check({name, "_dones"}, done_cyc.size(), 1);
    for (int i = 0; i < s_cyc.size() && i < total; i++) begin
      ed = (i < nd) ? int'(mem[i % NPIX]) : 0;
      es = (i < nd && (i % NPIX) == 0) ? 1 : 0;
      ee = (i < nd && (i % NPIX) == NPIX - 1) ? 1 : 0;
      check($sformatf("%s_data[%0d]", name, i), s_dat[i], ed);
      check($sformatf("%s_sof[%0d]", name, i), s_sof[i], es);
      check($sformatf("%s_eof[%0d]", name, i), s_eof[i], ee);
      if (timing) check($sformatf("%s_strb_cyc[%0d]", name, i), s_cyc[i] - e, 2 + i * per);
    end
    for (int i = 0; i < rd_addr.size() && i < nd; i++)
      check($sformatf("%s_addr[%0d]", name, i), rd_addr[i], i % NPIX);
    if (timing && done_cyc.size() > 0)
      check({name, "_done_cyc"}, done_cyc[0] - e, 2 + (total - 1) * per + 1);
  endtask

  initial begin
    int e, hits;
    bit got;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i * 37 + 5);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_strb", o_strb, 0);
    check("rst_data", o_data, 0);
    check("rst_sof", o_sof, 0);
    check("rst_eof", o_eof, 0);
    @(negedge clk) rst_n = 1'b1;

    start_job(1, 8, e);
    check("first_mem_rd", mem_rd, 1);
    check("first_addr", mem_addr, 0);
    check("first_busy", busy, 1);
    wait_done(2000);
    check_job("gap8", 1, 8, e, 1'b1);

    start_job(1, 3, e);
    wait_done(2000);
    check_job("gap3", 1, 8, e, 1'b1);

    start_job(1, 12, e);
    wait_done(2000);
    check_job("gap12", 1, 12, e, 1'b1);

    start_job(2, 8, e);
    wait_done(4000);
    check_job("two_frames", 2, 8, e, 1'b1);

    start_job(0, 8, e);
    wait_done(2000);
    check_job("zero_frames", 1, 8, e, 1'b1);

    // pause raised while pixel 3 is in flight, held for 20 cycles
    start_job(1, 8, e);
    for (int i = 0; i < 200 && cyc < e + 25; i++) begin
      @(posedge clk); #1;
    end
    pause = 1'b1;
    repeat (20) @(posedge clk);
    #1 pause = 1'b0;
    wait_done(2000);
    hits = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= e + 25 && rd_cyc[i] <= e + 44) hits++;
    check("pause_no_reads", hits, 0);
    check_job("pause", 1, 8, e, 1'b0);

    // start pulse with different settings while busy
    start_job(1, 8, e);
    for (int i = 0; i < 200 && cyc < e + 30; i++) @(negedge clk);
    gap = 8'd20; n_frames = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2000);
    check_job("busy_start", 1, 8, e, 1'b1);

    // asynchronous reset while a strobe is on the outputs
    start_job(1, 8, e);
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (o_strb && cyc > e + 20) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_strobe_found", got, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mem_rd", mem_rd, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_strb", o_strb, 0);
    check("arst_data", o_data, 0);
    check("arst_sof_eof", {o_sof, o_eof}, 0);
    repeat (3) @(negedge clk);
    check("arst_no_done", done_cyc.size(), 0);
    rst_n = 1'b1;
    start_job(1, 8, e);
    wait_done(2000);
    check_job("after_rst", 1, 8, e, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
